// File: rtl/fir_trace_recorder.sv
// fir_trace_recorder
// Builds one trace record per completed fir window: {x4..x0, dataout}, with
// x4 the newest sample. The window travels through a FIR_LAT-deep delay line
// so it meets the matching dataout, then lands in a show-ahead FIFO drained
// over a valid/ready port.
// Optional feature macro: FIR_TRACE_SEQ_EN prepends a 16-bit record sequence
// number (rec_data[65:50]); dropped records still consume a number.
module fir_trace_recorder #(
  parameter int FIR_LAT = 2,
  parameter int DEPTH   = 8,
  localparam int CW     = $clog2(DEPTH) + 1,
`ifdef FIR_TRACE_SEQ_EN
  localparam int REC_W  = 66
`else
  localparam int REC_W  = 50
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       x,
  input  logic             x_valid,
  input  logic [9:0]       dataout,
  output logic [REC_W-1:0] rec_data,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CW-1:0]    rec_count,
  output logic             overflow
);

  localparam int DATA_W = 8;
  localparam int TAPS   = 5;
  localparam int WIN_W  = TAPS * DATA_W;
  localparam int AW     = CW - 1;

  // Sample window and warm-up fill counter
  logic [WIN_W-1:0] win_q, win_d;
  logic [2:0]       fill_q, fill_d;

  // Alignment delay line: tag bit plus the window it belongs to
  logic             dl_vld_q [FIR_LAT];
  logic             dl_vld_d [FIR_LAT];
  logic [WIN_W-1:0] dl_win_q [FIR_LAT];
  logic [WIN_W-1:0] dl_win_d [FIR_LAT];

  // FIFO storage, pointers carry one extra wrap bit for full/empty
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic [REC_W-1:0] rec_new;

`ifdef FIR_TRACE_SEQ_EN
  logic [15:0]      seq_q, seq_d;
`endif

  // Shift the newest sample into x4 and count accepted samples up to five
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (x_valid) begin
      win_d = {x, win_q[WIN_W-1:DATA_W]};
      if (fill_q != 3'd5) begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  // Load stage 0 with the post-edge window, tagged when this edge completes it;
  // the line advances every cycle so gaps keep their alignment
  always_comb begin
    dl_vld_d[0] = x_valid && (fill_q >= 3'd4);
    dl_win_d[0] = win_d;
    for (int k = 1; k < FIR_LAT; k++) begin
      dl_vld_d[k] = dl_vld_q[k-1];
      dl_win_d[k] = dl_win_q[k-1];
    end
  end

  // ---- delay line exit: record assembly and FIFO control ----
  assign push      = dl_vld_q[FIR_LAT-1];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign rec_count = wr_ptr_q - rd_ptr_q;
  assign full      = (rec_count == CW'(DEPTH));
  assign pop       = !empty && rec_ready;
  // A pop frees the head slot at the same edge, so a full FIFO still accepts
  assign wr_en     = push && (!full || pop);

`ifdef FIR_TRACE_SEQ_EN
  assign rec_new = {seq_q, dl_win_q[FIR_LAT-1], dataout};
`else
  assign rec_new = {dl_win_q[FIR_LAT-1], dataout};
`endif

  // Pointer advance and sticky drop flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

`ifdef FIR_TRACE_SEQ_EN
  // Every record leaving the delay line takes a number, kept or dropped
  always_comb begin
    seq_d = seq_q;
    if (push) begin
      seq_d = seq_q + 16'd1;
    end
  end
`endif

  // State registers; reset clears everything including in-flight records
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < FIR_LAT; k++) begin
        dl_vld_q[k] <= 1'b0;
        dl_win_q[k] <= '0;
      end
    end else begin
      win_q    <= win_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      for (int k = 0; k < FIR_LAT; k++) begin
        dl_vld_q[k] <= dl_vld_d[k];
        dl_win_q[k] <= dl_win_d[k];
      end
    end
  end

`ifdef FIR_TRACE_SEQ_EN
  // Sequence counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end
`endif

  // FIFO storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rec_new;
    end
  end

  // ---- show-ahead output ----
  assign rec_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign rec_valid = !empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_trace_recorder.sv
// Bench for fir_trace_recorder: directed test-plan steps followed by a random
// run, checked cycle by cycle against a queue-based reference model.
module tb_fir_trace_recorder;

  localparam int FIR_LAT = 2;
  localparam int DEPTH   = 8;
  localparam int CW      = $clog2(DEPTH) + 1;
`ifdef FIR_TRACE_SEQ_EN
  localparam int REC_W   = 66;
`else
  localparam int REC_W   = 50;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       x;
  logic             x_valid;
  logic [9:0]       dataout;
  logic [REC_W-1:0] rec_data;
  logic             rec_valid;
  logic             rec_ready;
  logic [CW-1:0]    rec_count;
  logic             overflow;

  always #5 clk = ~clk;

  fir_trace_recorder #(.FIR_LAT(FIR_LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_valid   (x_valid),
    .dataout   (dataout),
    .rec_data  (rec_data),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_count (rec_count),
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: records due at a given edge, queued records, history
  typedef struct {
    int          due;
    logic [39:0] win;
  } pend_t;

  pend_t            pend [$];
  logic [REC_W-1:0] mq [$];
  logic [7:0]       hist [$];
  int               nacc = 0;
  int               cyc = 0;
  bit               m_ovf = 1'b0;
  int unsigned      seq_n = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply the rules at one rising edge using the inputs present at that edge
  task automatic model_edge();
    logic [REC_W-1:0] r;
    bit pop;
    bit full;
    bit do_push;
    r       = '0;
    do_push = 1'b0;
    if (rst) begin
      pend.delete();
      mq.delete();
      hist.delete();
      nacc  = 0;
      m_ovf = 1'b0;
      seq_n = 0;
      return;
    end
    pop  = (mq.size() > 0) && rec_ready;
    full = (mq.size() == DEPTH);
    if (pend.size() > 0 && pend[0].due == cyc) begin
`ifdef FIR_TRACE_SEQ_EN
      r = {seq_n[15:0], pend[0].win, dataout};
`else
      r = {pend[0].win, dataout};
`endif
      seq_n++;
      void'(pend.pop_front());
      if (full && !pop) m_ovf = 1'b1;
      else do_push = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (do_push) mq.push_back(r);
    if (x_valid) begin
      hist.push_back(x);
      if (hist.size() > 5) void'(hist.pop_front());
      if (nacc < 5) nacc++;
      if (nacc == 5)
        pend.push_back('{due: cyc + FIR_LAT, win: {hist[4], hist[3], hist[2], hist[1], hist[0]}});
    end
  endtask

  task automatic compare();
    check("rec_valid", 66'(rec_valid), 66'(mq.size() > 0));
    check("rec_count", 66'(rec_count), 66'(mq.size()));
    check("overflow", 66'(overflow), 66'(m_ovf));
    if (mq.size() > 0) check("rec_data", 66'(rec_data), 66'(mq[0]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare();
  endtask

  // dataout follows 100 + edge index, so the sampled edge is visible in records
  task automatic drive(input logic v, input logic [7:0] s);
    x_valid = v;
    x       = s;
    dataout = 10'(100 + cyc);
    cycle();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rec_ready = 1'b0;
    drive(1'b0, 8'd0);
    rst       = 1'b0;
  endtask

  initial begin
    int e5;
    int e15;
    x = '0; x_valid = 1'b0; dataout = '0; rec_ready = 1'b0; rst = 1'b1;
    #2;

    // Reset state
    do_reset();
    check("rst_valid", 66'(rec_valid), 66'(0));
    check("rst_count", 66'(rec_count), 66'(0));
    check("rst_ovf", 66'(overflow), 66'(0));
    check("rst_data", 66'(rec_data), 66'(0));

    // Warm-up: samples 1..6, first record belongs to sample 5
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) e5 = cyc;
      drive(1'b1, 8'(i));
      if (i <= 4) check("warm_none", 66'(rec_count), 66'(0));
    end
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    check("warm_count", 66'(rec_count), 66'(2));
    check("warm_win1", 66'(rec_data[49:10]), 66'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
    check("warm_dout1", 66'(rec_data[9:0]), 66'(100 + e5 + 2));
    rec_ready = 1'b1;
    drive(1'b0, 8'd0);
    rec_ready = 1'b0;
    check("warm_win2", 66'(rec_data[49:10]), 66'({8'd6, 8'd5, 8'd4, 8'd3, 8'd2}));
    check("warm_dout2", 66'(rec_data[9:0]), 66'(100 + e5 + 3));

    // Gaps: valid 1,1,1,1,1,0,0,1 with samples 10..15
    do_reset();
    for (int i = 10; i <= 14; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    e15 = cyc;
    drive(1'b1, 8'd15);
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    check("gap_count", 66'(rec_count), 66'(2));
    check("gap_win1", 66'(rec_data[49:10]), 66'({8'd14, 8'd13, 8'd12, 8'd11, 8'd10}));
    rec_ready = 1'b1;
    drive(1'b0, 8'd0);
    rec_ready = 1'b0;
    check("gap_win2", 66'(rec_data[49:10]), 66'({8'd15, 8'd14, 8'd13, 8'd12, 8'd11}));
    check("gap_dout2", 66'(rec_data[9:0]), 66'(100 + e15 + 2));

    // Backpressure: 12 completing samples into an 8-deep FIFO
    do_reset();
    for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    check("bp_count", 66'(rec_count), 66'(8));
    check("bp_ovf", 66'(overflow), 66'(1));
    check("bp_head", 66'(rec_data[49:10]), 66'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd0);
    rec_ready = 1'b0;
    check("bp_empty", 66'(rec_count), 66'(0));
    check("bp_ovf_hold", 66'(overflow), 66'(1));

    // Full FIFO with push and pop at the same edge
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      drive(1'b1, 8'(i));
      if (mq.size() == DEPTH) rec_ready = 1'b1;
    end
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    check("full_pp_count", 66'(rec_count), 66'(8));
    check("full_pp_ovf", 66'(overflow), 66'(0));
    for (int i = 0; i < 8; i++) drive(1'b0, 8'd0);
    rec_ready = 1'b0;

    // Mid-run reset: 5 queued, 2 in flight
    do_reset();
    for (int i = 1; i <= 11; i++) drive(1'b1, 8'(i + 40));
    check("mr_queued", 66'(rec_count), 66'(5));
    do_reset();
    check("mr_valid", 66'(rec_valid), 66'(0));
    check("mr_count", 66'(rec_count), 66'(0));
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i + 60));
    for (int i = 0; i < FIR_LAT + 2; i++) drive(1'b0, 8'd0);
    check("mr_warm", 66'(rec_count), 66'(0));
    drive(1'b1, 8'd65);
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    check("mr_first", 66'(rec_count), 66'(1));
    check("mr_win", 66'(rec_data[49:10]), 66'({8'd65, 8'd64, 8'd63, 8'd62, 8'd61}));

    // Sequence gaps from three dropped records
    do_reset();
    for (int i = 1; i <= 15; i++) drive(1'b1, 8'(i));
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    check("seq_count", 66'(rec_count), 66'(8));
    check("seq_ovf", 66'(overflow), 66'(1));
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef FIR_TRACE_SEQ_EN
      check("seq_num", 66'(rec_data[65:50]), 66'(i));
`endif
      drive(1'b0, 8'd0);
    end
    drive(1'b1, 8'd16);
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    check("seq_after", 66'(rec_count), 66'(1));
`ifdef FIR_TRACE_SEQ_EN
    check("seq_num11", 66'(rec_data[65:50]), 66'(11));
`endif
    rec_ready = 1'b0;

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      rec_ready = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 3) != 0), 8'($urandom));
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
